// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port of the multicycle fetch unit.
// Handshake: I_MEM_REQ and I_MEM_ADDR stay stable until a cycle with I_MEM_RDY=1, in which
// I_MEM_DI is valid and the read completes (RDY may arrive in the REQ cycle itself).
interface instr_fetch_unit_if;
    logic        I_MEM_REQ;
    logic [31:0] I_MEM_ADDR;
    logic        I_MEM_RDY;
    logic [31:0] I_MEM_DI;

    modport master (output I_MEM_REQ, output I_MEM_ADDR, input I_MEM_RDY, input I_MEM_DI);
    modport slave  (input I_MEM_REQ, input I_MEM_ADDR, output I_MEM_RDY, output I_MEM_DI);
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle RV32I fetch stage: PC, instruction register and IRWrite pulse for ID.
// Optional 1-entry prefetch buffer enabled by defining IF_PREFETCH_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic               CLK,
    input  logic               RSTn,
    instr_fetch_unit_if.master imem,
    input  logic               NEXT,
    input  logic               REDIRECT,
    input  logic [31:0]        REDIRECT_PC,
    output logic [31:0]        INSTR,
    output logic               IRWrite,
    output logic               INSTR_VALID,
    output logic [31:0]        PC,
    output logic               MISALIGN,
    output logic [CNT_W-1:0]   FETCH_CNT,
    output logic               dbg_state
);
    typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e      state, state_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic [31:0] deliver_data;
    logic        retire;
    logic        fetch_hit;
    logic        deliver;

    assign pc_plus4     = PC + 32'd4;
    assign redirect_tgt = {REDIRECT_PC[31:2], 2'b00};
    assign retire       = (state == S_HOLD) && NEXT;
    assign dbg_state    = (state == S_HOLD);

`ifdef IF_PREFETCH_EN
    logic [31:0] pf_buf;
    logic [31:0] stale_addr;
    logic        pf_valid;
    logic        discard;
    logic        pf_fill;

    // A read abandoned by a redirect must still be completed on the bus before the new one.
    assign fetch_hit = (state == S_FETCH) && imem.I_MEM_RDY && !discard;
    assign pf_fill   = (state == S_HOLD) && !pf_valid && imem.I_MEM_RDY && !retire;
`else
    assign fetch_hit = (state == S_FETCH) && imem.I_MEM_RDY;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (fetch_hit) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (NEXT) begin
`ifdef IF_PREFETCH_EN
                    if (REDIRECT || !(pf_valid || imem.I_MEM_RDY)) begin
                        state_nxt = S_FETCH;
                    end
`else
                    state_nxt = S_FETCH;
`endif
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        imem.I_MEM_REQ  = 1'b0;
        imem.I_MEM_ADDR = PC;
        case (state)
            S_FETCH: begin
                imem.I_MEM_REQ = RSTn;
`ifdef IF_PREFETCH_EN
                if (discard) begin
                    imem.I_MEM_ADDR = stale_addr;
                end
`endif
            end
            S_HOLD: begin
`ifdef IF_PREFETCH_EN
                imem.I_MEM_REQ  = RSTn && !pf_valid;
                imem.I_MEM_ADDR = pc_plus4;
`endif
            end
            default: imem.I_MEM_REQ = 1'b0;
        endcase
    end

    // A delivery is either a completed FETCH read or, with prefetch, a sequential retire.
    always_comb begin
        deliver      = fetch_hit;
        deliver_data = imem.I_MEM_DI;
`ifdef IF_PREFETCH_EN
        if (retire && !REDIRECT && (pf_valid || imem.I_MEM_RDY)) begin
            deliver = 1'b1;
            if (pf_valid) begin
                deliver_data = pf_buf;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            PC          <= RESET_PC;
            INSTR       <= 32'h0;
            IRWrite     <= 1'b0;
            INSTR_VALID <= 1'b0;
            MISALIGN    <= 1'b0;
            FETCH_CNT   <= '0;
        end else begin
            IRWrite <= deliver;
            if (deliver) begin
                INSTR     <= deliver_data;
                FETCH_CNT <= FETCH_CNT + CNT_ONE;
            end
            if (deliver) begin
                INSTR_VALID <= 1'b1;
            end else if (retire) begin
                INSTR_VALID <= 1'b0;
            end
            if (retire) begin
                PC <= REDIRECT ? redirect_tgt : pc_plus4;
                if (REDIRECT && (REDIRECT_PC[1:0] != 2'b00)) begin
                    MISALIGN <= 1'b1;
                end
            end
        end
    end

`ifdef IF_PREFETCH_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pf_buf     <= 32'h0;
            pf_valid   <= 1'b0;
            discard    <= 1'b0;
            stale_addr <= 32'h0;
        end else begin
            if (pf_fill) begin
                pf_buf   <= imem.I_MEM_DI;
                pf_valid <= 1'b1;
            end else if (retire) begin
                pf_valid <= 1'b0;
            end
            if (retire && REDIRECT && !pf_valid && !imem.I_MEM_RDY) begin
                discard    <= 1'b1;
                stale_addr <= pc_plus4;
            end else if ((state == S_FETCH) && discard && imem.I_MEM_RDY) begin
                discard <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// against an address-level model of the PC sequence and the memory contents.
module tb_instr_fetch_unit;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic        NEXT;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] INSTR;
    logic        IRWrite;
    logic        INSTR_VALID;
    logic [31:0] PC;
    logic        MISALIGN;
    logic [31:0] FETCH_CNT;
    logic        dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_mis;

    instr_fetch_unit_if imem();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .CLK(CLK), .RSTn(RSTn), .imem(imem), .NEXT(NEXT), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .INSTR(INSTR), .IRWrite(IRWrite),
        .INSTR_VALID(INSTR_VALID), .PC(PC), .MISALIGN(MISALIGN),
        .FETCH_CNT(FETCH_CNT), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Memory contents: word 0 is addi x1,x0,5; every other address maps to a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem.I_MEM_DI = mem_word(imem.I_MEM_ADDR);

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; NEXT = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; imem.I_MEM_RDY = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
        #1;
        exp_pc = 32'h0; exp_cnt = 32'h0; exp_mis = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; NEXT = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; imem.I_MEM_RDY = 1'b1;
        #1;
        total_cnt++; if (imem.I_MEM_REQ !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem.I_MEM_REQ); else pass_cnt++;
        total_cnt++; if (PC !== 32'h0) $display("FAIL reset_pc: got %h want 0", PC); else pass_cnt++;
        total_cnt++; if (INSTR !== 32'h0) $display("FAIL reset_instr: got %h want 0", INSTR); else pass_cnt++;
        total_cnt++; if (IRWrite !== 1'b0 || INSTR_VALID !== 1'b0) $display("FAIL reset_flags: irw=%0b valid=%0b want 0 0", IRWrite, INSTR_VALID); else pass_cnt++;
        total_cnt++; if (MISALIGN !== 1'b0 || FETCH_CNT !== 32'h0) $display("FAIL reset_mis_cnt: mis=%0b cnt=%0d want 0 0", MISALIGN, FETCH_CNT); else pass_cnt++;
        total_cnt++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %0b want 0 (FETCH)", dbg_state); else pass_cnt++;
        tick();
        total_cnt++; if (IRWrite !== 1'b0 || FETCH_CNT !== 32'h0) $display("FAIL reset_held: irw=%0b cnt=%0d want 0 0", IRWrite, FETCH_CNT); else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        imem.I_MEM_RDY = 1'b1;
        RSTn = 1'b1;
        tick();
        imem.I_MEM_RDY = 1'b0;
        total_cnt++; if (IRWrite !== 1'b1) $display("FAIL first_irwrite: got %0b want 1", IRWrite); else pass_cnt++;
        total_cnt++; if (INSTR !== 32'h0050_0093) $display("FAIL first_instr: got %h want 00500093", INSTR); else pass_cnt++;
        total_cnt++; if (PC !== 32'h0 || INSTR_VALID !== 1'b1) $display("FAIL first_pc_valid: pc=%h valid=%0b want 0 1", PC, INSTR_VALID); else pass_cnt++;
        total_cnt++; if (imem.I_MEM_REQ !== 1'b0) $display("FAIL first_hold_req: got %0b want 0", imem.I_MEM_REQ); else pass_cnt++;
        tick();
        total_cnt++; if (IRWrite !== 1'b0 || INSTR !== 32'h0050_0093) $display("FAIL first_pulse_end: irw=%0b instr=%h want 0 00500093", IRWrite, INSTR); else pass_cnt++;
    endtask

    task automatic test_delayed_rdy();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            total_cnt++; if (imem.I_MEM_REQ !== 1'b1 || imem.I_MEM_ADDR !== 32'h0 || IRWrite !== 1'b0)
                $display("FAIL delay_wait%0d: req=%0b addr=%h irw=%0b want 1 0 0", k, imem.I_MEM_REQ, imem.I_MEM_ADDR, IRWrite); else pass_cnt++;
            tick();
        end
        imem.I_MEM_RDY = 1'b1;
        tick();
        imem.I_MEM_RDY = 1'b0;
        total_cnt++; if (IRWrite !== 1'b1 || FETCH_CNT !== 32'd1) $display("FAIL delay_done: irw=%0b cnt=%0d want 1 1", IRWrite, FETCH_CNT); else pass_cnt++;
        tick();
        total_cnt++; if (IRWrite !== 1'b0 || FETCH_CNT !== 32'd1) $display("FAIL delay_single: irw=%0b cnt=%0d want 0 1", IRWrite, FETCH_CNT); else pass_cnt++;
    endtask

    task automatic test_redirect();
        NEXT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0102;
        tick();
        NEXT = 1'b0; REDIRECT = 1'b0;
        total_cnt++; if (PC !== 32'h100 || MISALIGN !== 1'b1) $display("FAIL redir_pc_mis: pc=%h mis=%0b want 00000100 1", PC, MISALIGN); else pass_cnt++;
        total_cnt++; if (imem.I_MEM_REQ !== 1'b1 || imem.I_MEM_ADDR !== 32'h100 || INSTR_VALID !== 1'b0)
            $display("FAIL redir_req: req=%0b addr=%h valid=%0b want 1 00000100 0", imem.I_MEM_REQ, imem.I_MEM_ADDR, INSTR_VALID); else pass_cnt++;
        // Control pulses during FETCH must have no effect.
        NEXT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_5550;
        tick();
        NEXT = 1'b0; REDIRECT = 1'b0;
        total_cnt++; if (PC !== 32'h100 || dbg_state !== 1'b0) $display("FAIL fetch_ignores_next: pc=%h state=%0b want 00000100 0", PC, dbg_state); else pass_cnt++;
        imem.I_MEM_RDY = 1'b1;
        tick();
        imem.I_MEM_RDY = 1'b0;
        total_cnt++; if (IRWrite !== 1'b1 || INSTR !== mem_word(32'h100) || FETCH_CNT !== 32'd2)
            $display("FAIL redir_fetch: irw=%0b instr=%h cnt=%0d want 1 %h 2", IRWrite, INSTR, FETCH_CNT, mem_word(32'h100)); else pass_cnt++;
    endtask

    task automatic test_wrap();
        NEXT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
        tick();
        NEXT = 1'b0; REDIRECT = 1'b0; imem.I_MEM_RDY = 1'b1;
        tick();
        imem.I_MEM_RDY = 1'b0;
        total_cnt++; if (PC !== 32'hFFFF_FFFC || INSTR !== mem_word(32'hFFFF_FFFC))
            $display("FAIL wrap_top: pc=%h instr=%h want fffffffc %h", PC, INSTR, mem_word(32'hFFFF_FFFC)); else pass_cnt++;
        NEXT = 1'b1;
        tick();
        NEXT = 1'b0;
        total_cnt++; if (PC !== 32'h0 || imem.I_MEM_ADDR !== 32'h0 || imem.I_MEM_REQ !== 1'b1)
            $display("FAIL wrap_zero: pc=%h addr=%h req=%0b want 0 0 1", PC, imem.I_MEM_ADDR, imem.I_MEM_REQ); else pass_cnt++;
        total_cnt++; if (MISALIGN !== 1'b1) $display("FAIL mis_sticky: got %0b want 1", MISALIGN); else pass_cnt++;
        imem.I_MEM_RDY = 1'b1;
        tick();
        imem.I_MEM_RDY = 1'b0;
        total_cnt++; if (INSTR !== 32'h0050_0093 || FETCH_CNT !== 32'd4) $display("FAIL wrap_fetch: instr=%h cnt=%0d want 00500093 4", INSTR, FETCH_CNT); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fetch();
        NEXT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_3000;
        tick();
        NEXT = 1'b0; REDIRECT = 1'b0;
        tick();
        imem.I_MEM_RDY = 1'b1;
        RSTn = 1'b0;
        #1;
        total_cnt++; if (imem.I_MEM_REQ !== 1'b0 || PC !== 32'h0 || INSTR !== 32'h0)
            $display("FAIL midrst_async: req=%0b pc=%h instr=%h want 0 0 0", imem.I_MEM_REQ, PC, INSTR); else pass_cnt++;
        total_cnt++; if (MISALIGN !== 1'b0 || FETCH_CNT !== 32'h0 || INSTR_VALID !== 1'b0 || IRWrite !== 1'b0)
            $display("FAIL midrst_flags: mis=%0b cnt=%0d valid=%0b irw=%0b want 0 0 0 0", MISALIGN, FETCH_CNT, INSTR_VALID, IRWrite); else pass_cnt++;
        tick();
        total_cnt++; if (IRWrite !== 1'b0 || FETCH_CNT !== 32'h0 || INSTR !== 32'h0)
            $display("FAIL midrst_noirw: irw=%0b cnt=%0d instr=%h want 0 0 0", IRWrite, FETCH_CNT, INSTR); else pass_cnt++;
        imem.I_MEM_RDY = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        logic [31:0] want_w;
        int          lat;
        int          hold;
        bit          redir;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            exp_q.push_back(mem_word(exp_pc));
            lat = $urandom_range(0, 3);
            for (int k = 0; k <= lat; k++) begin
                total_cnt++; if (imem.I_MEM_REQ !== 1'b1 || imem.I_MEM_ADDR !== exp_pc || IRWrite !== 1'b0)
                    $display("FAIL rand_req it%0d: req=%0b addr=%h irw=%0b want 1 %h 0", it, imem.I_MEM_REQ, imem.I_MEM_ADDR, IRWrite, exp_pc); else pass_cnt++;
                if (k == lat) imem.I_MEM_RDY = 1'b1;
                tick();
            end
            imem.I_MEM_RDY = 1'b0;
            exp_cnt = exp_cnt + 32'd1;
            want_w = exp_q.pop_front();
            total_cnt++; if (IRWrite !== 1'b1 || INSTR !== want_w || PC !== exp_pc)
                $display("FAIL rand_deliver it%0d: irw=%0b instr=%h pc=%h want 1 %h %h", it, IRWrite, INSTR, PC, want_w, exp_pc); else pass_cnt++;
            total_cnt++; if (FETCH_CNT !== exp_cnt || INSTR_VALID !== 1'b1)
                $display("FAIL rand_cnt it%0d: cnt=%0d valid=%0b want %0d 1", it, FETCH_CNT, INSTR_VALID, exp_cnt); else pass_cnt++;
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                imem.I_MEM_RDY = 1'($urandom_range(0, 1));
                tick();
                total_cnt++; if (IRWrite !== 1'b0 || imem.I_MEM_REQ !== 1'b0 || INSTR !== want_w)
                    $display("FAIL rand_hold it%0d: irw=%0b req=%0b instr=%h want 0 0 %h", it, IRWrite, imem.I_MEM_REQ, INSTR, want_w); else pass_cnt++;
            end
            imem.I_MEM_RDY = 1'b0;
            redir = ($urandom_range(0, 3) == 0);
            tgt = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 3))) : 32'($urandom);
            if (redir) begin
                exp_pc  = {tgt[31:2], 2'b00};
                exp_mis = exp_mis | (tgt[1:0] != 2'b00);
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
            NEXT = 1'b1; REDIRECT = redir; REDIRECT_PC = tgt;
            tick();
            NEXT = 1'b0; REDIRECT = 1'b0;
            total_cnt++; if (PC !== exp_pc || MISALIGN !== exp_mis || IRWrite !== 1'b0 || INSTR_VALID !== 1'b0)
                $display("FAIL rand_next it%0d: pc=%h mis=%0b irw=%0b valid=%0b want %h %0b 0 0", it, PC, MISALIGN, IRWrite, INSTR_VALID, exp_pc, exp_mis); else pass_cnt++;
        end
    endtask

`ifdef IF_PREFETCH_EN
    task automatic test_prefetch();
        logic [31:0] stale_w;
        bit          seen;
        imem.I_MEM_RDY = 1'b1;
        RSTn = 1'b1;
        tick();
        exp_pc = 32'h0;
        total_cnt++; if (IRWrite !== 1'b1 || INSTR !== mem_word(32'h0)) $display("FAIL pf_first: irw=%0b instr=%h want 1 %h", IRWrite, INSTR, mem_word(32'h0)); else pass_cnt++;
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 1)) tick();
            NEXT = 1'b1;
            tick();
            NEXT = 1'b0;
            exp_pc = exp_pc + 32'd4;
            total_cnt++; if (IRWrite !== 1'b1 || INSTR !== mem_word(exp_pc) || PC !== exp_pc)
                $display("FAIL pf_seq%0d: irw=%0b instr=%h pc=%h want 1 %h %h", n, IRWrite, INSTR, PC, mem_word(exp_pc), exp_pc); else pass_cnt++;
        end
        total_cnt++; if (FETCH_CNT !== 32'd5) $display("FAIL pf_cnt: got %0d want 5", FETCH_CNT); else pass_cnt++;
        imem.I_MEM_RDY = 1'b0;
        stale_w = mem_word(exp_pc + 32'd4);
        NEXT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0200;
        tick();
        NEXT = 1'b0; REDIRECT = 1'b0;
        total_cnt++; if (PC !== 32'h200 || imem.I_MEM_REQ !== 1'b1 || IRWrite !== 1'b0)
            $display("FAIL pf_redir: pc=%h req=%0b irw=%0b want 00000200 1 0", PC, imem.I_MEM_REQ, IRWrite); else pass_cnt++;
        imem.I_MEM_RDY = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            tick();
            total_cnt++; if (INSTR === stale_w) $display("FAIL pf_stale: instr=%h must not be stale word", INSTR); else pass_cnt++;
            if (IRWrite === 1'b1) begin
                seen = 1'b1;
                total_cnt++; if (INSTR !== mem_word(32'h200) || PC !== 32'h200)
                    $display("FAIL pf_target: instr=%h pc=%h want %h 00000200", INSTR, PC, mem_word(32'h200)); else pass_cnt++;
            end
        end
        total_cnt++; if (!seen || FETCH_CNT !== 32'd6) $display("FAIL pf_target_seen: seen=%0b cnt=%0d want 1 6", seen, FETCH_CNT); else pass_cnt++;
        imem.I_MEM_RDY = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef IF_PREFETCH_EN
        test_prefetch();
`else
        test_first_fetch();
        test_delayed_rdy();
        test_redirect();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
